// File: rtl/rf_wb_arbiter_pkg.sv
// Shared widths, default starvation limit and writeback source IDs for the
// register-file writeback arbiter.
package rf_wb_arbiter_pkg;

    localparam int RAW            = 5;
    localparam int DW             = 32;
    localparam int STARVE_MAX_DEF = 3;

    typedef enum logic {
        WB_SRC_EXU = 1'b0,
        WB_SRC_LSU = 1'b1
    } wb_src_e;

endpackage

// File: rtl/rf_wb_arbiter_wb_starve_cnt.sv
// Saturating count of consecutive cycles a valid EXU request lost arbitration;
// o_starved forces the next EXU grant.
module wb_starve_cnt #(
    parameter int STARVE_MAX = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_starved
);

    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [CW-1:0] r_cnt;

    assign o_starved = (r_cnt == CW'(STARVE_MAX));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !o_starved) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the register-file write port between EXU and LSU writebacks
// (LSU priority, EXU anti-starvation), one registered stage. WB_FWD_EN adds forwarding.
module rf_wb_arbiter #(
    parameter int RAW        = rf_wb_arbiter_pkg::RAW,
    parameter int DW         = rf_wb_arbiter_pkg::DW,
    parameter int STARVE_MAX = rf_wb_arbiter_pkg::STARVE_MAX_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_exu_valid,
    output logic           o_exu_ready,
    input  logic [RAW-1:0] i_exu_rd,
    input  logic [DW-1:0]  i_exu_data,
    input  logic           i_lsu_valid,
    output logic           o_lsu_ready,
    input  logic [RAW-1:0] i_lsu_rd,
    input  logic [DW-1:0]  i_lsu_data,
    output logic           o_rf_write_en,
    output logic [RAW-1:0] o_rf_write_reg,
    output logic [DW-1:0]  o_rf_write_data
`ifdef WB_FWD_EN
    ,
    input  logic [RAW-1:0] i_fwd_rs1,
    input  logic [RAW-1:0] i_fwd_rs2,
    output logic           o_fwd1_hit,
    output logic           o_fwd2_hit,
    output logic [DW-1:0]  o_fwd1_data,
    output logic [DW-1:0]  o_fwd2_data
`endif
);

    import rf_wb_arbiter_pkg::*;

    logic           w_starved;
    logic           w_xfer;
    logic           w_cnt_clr;
    logic           w_cnt_inc;
    wb_src_e        w_src;
    logic [RAW-1:0] w_rd;
    logic [DW-1:0]  w_data;

    logic           r_en;
    logic [RAW-1:0] r_reg;
    logic [DW-1:0]  r_data;

    // LSU wins unless a waiting EXU request has hit the starvation limit.
    assign o_lsu_ready = !rst & i_lsu_valid & (!i_exu_valid | !w_starved);
    assign o_exu_ready = !rst & i_exu_valid & !o_lsu_ready;
    assign w_xfer      = o_lsu_ready | o_exu_ready;

    assign w_cnt_clr = !i_exu_valid | o_exu_ready;
    assign w_cnt_inc = i_exu_valid & !o_exu_ready;

    wb_starve_cnt #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_cnt (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_cnt_clr),
        .i_inc     (w_cnt_inc),
        .o_starved (w_starved)
    );

    // NOTE: every combinational output gets a default first, so no path infers a latch.
    always_comb begin
        w_src  = o_exu_ready ? WB_SRC_EXU : WB_SRC_LSU;
        w_rd   = i_lsu_rd;
        w_data = i_lsu_data;
        case (w_src)
            WB_SRC_EXU: begin
                w_rd   = i_exu_rd;
                w_data = i_exu_data;
            end
            default: begin
                w_rd   = i_lsu_rd;
                w_data = i_lsu_data;
            end
        endcase
    end

    // Writes to x0 are accepted upstream but never enabled at the file.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_en   <= 1'b0;
            r_reg  <= '0;
            r_data <= '0;
        end else begin
            r_en <= w_xfer && (w_rd != '0);
            if (w_xfer) begin
                r_reg  <= w_rd;
                r_data <= w_data;
            end
        end
    end

    assign o_rf_write_en   = r_en;
    assign o_rf_write_reg  = r_reg;
    assign o_rf_write_data = r_data;

`ifdef WB_FWD_EN
    // The file's read ports still return old data while this write is pending.
    assign o_fwd1_hit  = r_en && (i_fwd_rs1 == r_reg) && (i_fwd_rs1 != '0);
    assign o_fwd2_hit  = r_en && (i_fwd_rs2 == r_reg) && (i_fwd_rs2 != '0);
    assign o_fwd1_data = r_data;
    assign o_fwd2_data = r_data;
`endif

endmodule
